bank_responder: RTL
===================

Name: bank_responder

Overview:
- Responder end of the request/grant handshake for one memory bank.
- Takes the one-hot grant from the bank's round-robin arbiter and captures the granted requester's command (address, write enable, write data).
- Runs a fixed-latency access on a local storage array, then returns ack, read data and an error flag to that requester only.
- One instance per bank; it sits between the arbiter and the bank storage.

Parameters:
- N, 5, number of requesters; matches the arbiter width.
- AW, 4, address width per requester.
- DW, 8, data width.
- DEPTH, 16, number of storage words; DEPTH <= 2**AW.
- LATENCY, 2, access cycles spent in BUSY; legal values are >= 1.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- req  input  N  raw request vector, the same one driven into the arbiter.
- grant  input  N  one-hot grant from the arbiter (combinational from req).
- addr  input  N*AW  flattened addresses; requester i drives bits [i*AW +: AW].
- we  input  N  per-requester write enable (1 = write, 0 = read).
- wdata  input  N*DW  flattened write data; requester i drives bits [i*DW +: DW].
- ack  output  N  one-hot completion pulse to the served requester.
- rdata  output  DW  read data; valid in the cycle ack is high for a read.
- err  output  1  high together with ack when the served address is >= DEPTH.
- busy  output  1  high whenever state is not IDLE.
- proto_err  output  1  sticky flag: a non-one-hot grant was seen in IDLE.

Behaviour:
- Reset (rst_n sampled low at a clock edge):
  - state <= IDLE; ack, err, busy, proto_err <= 0; rdata <= 0; internal counter <= 0.
  - Storage contents are not reset.
  - Reset overrides every state, including mid-BUSY and RESP; an in-flight access is dropped with no ack and no write.
- Command qualifier: g = grant & req.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - g == 0: stay in IDLE.
  - g one-hot: capture index i, addr_i, we_i, wdata_i; counter <= LATENCY-1; go to BUSY.
  - g has more than one bit set: capture nothing, proto_err <= 1 (held until reset), stay in IDLE.
- BUSY:
  - Counter decrements each cycle.
  - In the cycle the counter is 0, perform the access and go to RESP:
    - Write with captured addr < DEPTH: mem[addr] <= wdata.
    - Read with addr < DEPTH: rdata <= mem[addr].
    - addr >= DEPTH: no write; rdata <= 0; err <= 1.
- RESP:
  - ack[i] = 1 for exactly one cycle, with err valid; then go to IDLE.
  - ack, err and busy are registered outputs.
- Timing, grant captured at edge of cycle T:
  - BUSY during cycles T+1 .. T+LATENCY.
  - ack high during cycle T+LATENCY+1.
  - IDLE again at T+LATENCY+2; a new grant is capturable that cycle.
  - Back-to-back throughput is one command per LATENCY+2 cycles.
- rdata holds its last read value until the next read completes. Writes do not change rdata.
- Requester obligations:
  - Hold req, addr, we and wdata stable from assertion until it samples ack.
  - Drop req (or present a new command) in the cycle after ack.
  - The responder ignores grant and req changes while in BUSY or RESP.
- Read-after-write to the same address from any requester returns the new data, because accesses are strictly serialized.

Test Plan:
- Reset: hold rst_n = 0 for 2 cycles -> ack = 0, err = 0, busy = 0, proto_err = 0, rdata = 0.
- Write/read, LATENCY = 2:
  - Requester 1 writes addr 3 = 0xA5, grant captured at cycle 10 -> busy in cycles 11-12, ack = 5'b00010 in cycle 13, err = 0.
  - Requester 1 then reads addr 3 -> rdata = 0xA5 with its ack.
- Contention: requesters 0 and 2 request together through the real arbiter -> two serialized transactions, acks 5'b00001 then 5'b00100, each exactly LATENCY+2 cycles apart, no overlap.
- Out of range, DEPTH = 16, AW = 5: read of addr 20 -> ack with err = 1, rdata = 0. Write to addr 20 does not alter mem[4] (4 = 20 mod 16).
- Protocol error: force grant = 5'b00110 with matching req in IDLE -> no capture, busy stays 0, proto_err = 1 and held until rst_n low.
- Reset mid-operation: assert rst_n = 0 in the first BUSY cycle of a write to addr 5 -> no ack. A later read of addr 5 returns its prior value, and busy is 0 the cycle after reset.

Source files
------------

// File: rtl/bank_responder.sv
// rtl/bank_responder.sv - single-bank responder: captures granted command, fixed-latency access, one-hot ack
// Serializes one command at a time from the arbiter grant onto the local storage array.
module bank_responder #(
   parameter int N       = 5,
   parameter int AW      = 4,
   parameter int DW      = 8,
   parameter int DEPTH   = 16,
   parameter int LATENCY = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N-1:0]    req,
   input  logic [N-1:0]    grant,
   input  logic [N*AW-1:0] addr,
   input  logic [N-1:0]    we,
   input  logic [N*DW-1:0] wdata,
   output logic [N-1:0]    ack,
   output logic [DW-1:0]   rdata,
   output logic            err,
   output logic            busy,
   output logic            proto_err
);

   localparam int CW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam int MIW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];

   typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [CW-1:0]   r_cnt;
   logic [N-1:0]    r_sel;
   logic [AW-1:0]   r_addr;
   logic            r_we;
   logic [DW-1:0]   r_wdata;
   logic [N-1:0]    r_ack;
   logic            r_err;
   logic            r_busy;
   logic            r_proto;
   logic [DW-1:0]   r_rdata;
   logic [DW-1:0]   r_mem [DEPTH];

   logic [N-1:0]    w_g;
   logic            w_capture;
   logic            w_multi;
   logic            w_access;
   logic            w_in_range;
   logic [MIW-1:0]  w_mem_idx;
   logic [AW-1:0]   w_cap_addr;
   logic            w_cap_we;
   logic [DW-1:0]   w_cap_wdata;
   logic [N-1:0]    w_ack_nxt;
   logic            w_err_nxt;
   logic            w_busy_nxt;
   logic            w_proto_nxt;
   logic [DW-1:0]   w_rdata_nxt;

   assign w_g        = grant & req;
   assign w_capture  = (r_state == ST_IDLE) && $onehot(w_g);
   assign w_multi    = (r_state == ST_IDLE) && (w_g != '0) && !$onehot(w_g);
   assign w_access   = (r_state == ST_BUSY) && (r_cnt == '0);
   assign w_in_range = ({1'b0, r_addr} < DEPTH_W);
   assign w_mem_idx  = r_addr[MIW-1:0];

   // Command mux: g is one-hot whenever the result is used, so the last hit wins harmlessly.
   always_comb begin
      w_cap_addr  = '0;
      w_cap_we    = 1'b0;
      w_cap_wdata = '0;
      for (int i = 0; i < N; i++) begin
         if (w_g[i]) begin
            w_cap_addr  = addr[i*AW +: AW];
            w_cap_we    = we[i];
            w_cap_wdata = wdata[i*DW +: DW];
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_capture) w_state_nxt = ST_BUSY;
         ST_BUSY: if (r_cnt == '0) w_state_nxt = ST_RESP;
         ST_RESP: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_ack_nxt   = '0;
      w_err_nxt   = 1'b0;
      w_busy_nxt  = (w_state_nxt != ST_IDLE);
      w_proto_nxt = r_proto | w_multi;
      w_rdata_nxt = r_rdata;
      if (w_access) begin
         w_ack_nxt = r_sel;
         w_err_nxt = !w_in_range;
         if (!w_in_range)
            w_rdata_nxt = '0;
         else if (!r_we)
            w_rdata_nxt = r_mem[w_mem_idx];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_sel   <= '0;
         r_addr  <= '0;
         r_we    <= 1'b0;
         r_wdata <= '0;
         r_ack   <= '0;
         r_err   <= 1'b0;
         r_busy  <= 1'b0;
         r_proto <= 1'b0;
         r_rdata <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ack   <= w_ack_nxt;
         r_err   <= w_err_nxt;
         r_busy  <= w_busy_nxt;
         r_proto <= w_proto_nxt;
         r_rdata <= w_rdata_nxt;
         if (w_capture) begin
            r_sel   <= w_g;
            r_addr  <= w_cap_addr;
            r_we    <= w_cap_we;
            r_wdata <= w_cap_wdata;
            r_cnt   <= CW'(LATENCY - 1);
         end else if ((r_state == ST_BUSY) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CW'(1);
         end
      end
   end

   // Storage is not reset; reset still suppresses an in-flight write.
   always_ff @(posedge clk) begin
      if (rst_n && w_access && r_we && w_in_range)
         r_mem[w_mem_idx] <= r_wdata;
   end

   assign ack       = r_ack;
   assign rdata     = r_rdata;
   assign err       = r_err;
   assign busy      = r_busy;
   assign proto_err = r_proto;

endmodule
